// File: rtl/aes_decrypt_iter.sv
// rtl/aes_decrypt_iter.sv - iterative AES-128 decryption core with on-the-fly inverse key schedule
module aes_decrypt_iter #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_decryption,
    input  logic [127:0] ciphertext_in,
    input  logic [127:0] key_in,
    output logic [127:0] plaintext_out,
    output logic         decryption_done,
    output logic         busy
);

    // Only the AES-128 schedule is implemented; reject anything else at elaboration.
    generate
        if (NUM_ROUNDS != 10) begin : g_num_rounds_check
            $error("aes_decrypt_iter supports NUM_ROUNDS = 10 only");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, EXPAND, ADD0, ROUND} state_t;

    state_t       state;
    state_t       state_next;
    logic [127:0] state_reg;
    logic [127:0] key_reg;
    logic [3:0]   rnd;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    // S-box tables expressed algebraically; each collapses to a 256-entry combinational ROM.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] v;
        v = gf_inv(x);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [7:0] v;
        v = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
        return gf_inv(v);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
        return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

    function automatic logic [127:0] fwd_key_step(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] n0, n1, n2, n3;
        n0 = k[127:96] ^ sub_rot_word(k[31:0]) ^ {rc, 24'h000000};
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    function automatic logic [127:0] inv_key_step(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] n0, n1, n2, n3;
        n3 = k[31:0] ^ k[63:32];
        n2 = k[63:32] ^ k[95:64];
        n1 = k[95:64] ^ k[127:96];
        n0 = k[127:96] ^ sub_rot_word(n3) ^ {rc, 24'h000000};
        return {n0, n1, n2, n3};
    endfunction

    // Row r of the column-major state rotates right by r columns.
    function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                o[127-8*(r+4*c) -: 8] = inv_sbox(s[127-8*(r+4*((c-r+4)%4)) -: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

    logic [127:0] round_pre;
    logic [127:0] round_mixed;
    logic [127:0] key_fwd;
    logic [127:0] key_inv;

    // Shared round datapath; rnd selects Rcon for both key directions.
    always_comb begin
        round_pre   = inv_shift_sub(state_reg) ^ key_reg;
        round_mixed = inv_mix_columns(round_pre);
        key_fwd     = fwd_key_step(key_reg, rcon(rnd));
        key_inv     = inv_key_step(key_reg, rcon(rnd));
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state decode: expand to key 10, whiten once, then ten inverse rounds.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_decryption) state_next = EXPAND;
            EXPAND:  if (rnd == 4'd10)     state_next = ADD0;
            ADD0:                          state_next = ROUND;
            ROUND:   if (rnd == 4'd0)      state_next = IDLE;
            default:                       state_next = IDLE;
        endcase
    end

    // Datapath, round counter and handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= '0;
            key_reg         <= '0;
            rnd             <= '0;
            plaintext_out   <= '0;
            decryption_done <= 1'b0;
            busy            <= 1'b0;
        end else begin
            decryption_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_decryption) begin
                        state_reg <= ciphertext_in;
                        key_reg   <= key_in;
                        rnd       <= 4'd1;
                        busy      <= 1'b1;
                    end
                end
                EXPAND: begin
                    key_reg <= key_fwd;
                    if (rnd != 4'd10) rnd <= rnd + 4'd1;
                end
                ADD0: begin
                    state_reg <= state_reg ^ key_reg;
                    key_reg   <= key_inv;
                    rnd       <= 4'd9;
                end
                ROUND: begin
                    key_reg <= key_inv;
                    if (rnd == 4'd0) begin
                        plaintext_out   <= round_pre;
                        decryption_done <= 1'b1;
                        busy            <= 1'b0;
                    end else begin
                        state_reg <= round_mixed;
                        rnd       <= rnd - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
